// File: rtl/dither_pixel_writer.sv
// Packs dithered R/G/B channel bytes into RGB444 words and writes them to the VGA frame buffer in raster order.
// Optional SOF resynchronisation in GET_R is enabled by defining DITHER_PIXEL_WRITER_SOF_RESYNC_EN.
module dither_pixel_writer #(
    parameter int unsigned H_PIXELS = 320,
    parameter int unsigned V_PIXELS = 240,
    parameter int unsigned ADDR_W   = 17
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [7:0]        in_color,
    input  logic              in_sof,
    output logic              fb_we,
    input  logic              fb_ready,
    output logic [ADDR_W-1:0] fb_addr,
    output logic [11:0]       fb_data,
    output logic              frame_done,
    output logic              dith_clr,
    output logic              sync_err
);

    localparam int unsigned XW = (H_PIXELS > 1) ? $clog2(H_PIXELS) : 1;
    localparam int unsigned YW = (V_PIXELS > 1) ? $clog2(V_PIXELS) : 1;

    typedef enum logic [2:0] {
        WAIT_SOF = 3'd0,
        GET_R    = 3'd1,
        GET_G    = 3'd2,
        GET_B    = 3'd3,
        WRITE    = 3'd4
    } state_t;

    state_t            state, state_nxt;
    logic [XW-1:0]     x, x_nxt;
    logic [YW-1:0]     y, y_nxt;
    logic [3:0]        r, r_nxt;
    logic [3:0]        g, g_nxt;
    logic [ADDR_W-1:0] addr_nxt;
    logic [11:0]       data_nxt;
    logic              we_nxt, done_nxt, clr_nxt, err_nxt;
    logic              xfer, last_px, resync;
    logic              unused_low_nibble;

    // Low nibble carries only dither residue and is discarded.
    assign unused_low_nibble = ^in_color[3:0];

    // Ready depends on state only, forced low while reset is held.
    assign in_ready = rst && (state != WRITE);
    assign xfer     = in_valid && in_ready;
    assign last_px  = (x == XW'(H_PIXELS - 1)) && (y == YW'(V_PIXELS - 1));

`ifdef DITHER_PIXEL_WRITER_SOF_RESYNC_EN
    assign resync = (state == GET_R) && xfer && in_sof && (fb_addr != '0);
`else
    assign resync = 1'b0;
`endif

    always_comb begin
        state_nxt = state;
        x_nxt     = x;
        y_nxt     = y;
        r_nxt     = r;
        g_nxt     = g;
        addr_nxt  = fb_addr;
        data_nxt  = fb_data;
        we_nxt    = fb_we;
        done_nxt  = 1'b0;
        clr_nxt   = 1'b0;
        err_nxt   = 1'b0;
        case (state)
            WAIT_SOF: begin
                if (xfer && in_sof) begin
                    r_nxt     = in_color[7:4];
                    clr_nxt   = 1'b1;
                    state_nxt = GET_G;
                end
            end
            GET_R: begin
                if (xfer) begin
                    r_nxt     = in_color[7:4];
                    state_nxt = GET_G;
                    if (resync) begin
                        err_nxt  = 1'b1;
                        clr_nxt  = 1'b1;
                        x_nxt    = '0;
                        y_nxt    = '0;
                        addr_nxt = '0;
                    end
                end
            end
            GET_G: begin
                if (xfer) begin
                    g_nxt     = in_color[7:4];
                    state_nxt = GET_B;
                end
            end
            GET_B: begin
                if (xfer) begin
                    data_nxt  = {r, g, in_color[7:4]};
                    we_nxt    = 1'b1;
                    state_nxt = WRITE;
                end
            end
            WRITE: begin
                if (fb_we && fb_ready) begin
                    we_nxt = 1'b0;
                    if (last_px) begin
                        x_nxt     = '0;
                        y_nxt     = '0;
                        addr_nxt  = '0;
                        done_nxt  = 1'b1;
                        state_nxt = WAIT_SOF;
                    end else begin
                        addr_nxt  = fb_addr + ADDR_W'(1);
                        state_nxt = GET_R;
                        if (x == XW'(H_PIXELS - 1)) begin
                            x_nxt = '0;
                            y_nxt = y + YW'(1);
                        end else begin
                            x_nxt = x + XW'(1);
                        end
                    end
                end
            end
            default: state_nxt = WAIT_SOF;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= WAIT_SOF;
            x          <= '0;
            y          <= '0;
            r          <= '0;
            g          <= '0;
            fb_addr    <= '0;
            fb_data    <= '0;
            fb_we      <= 1'b0;
            frame_done <= 1'b0;
            dith_clr   <= 1'b0;
            sync_err   <= 1'b0;
        end else begin
            state      <= state_nxt;
            x          <= x_nxt;
            y          <= y_nxt;
            r          <= r_nxt;
            g          <= g_nxt;
            fb_addr    <= addr_nxt;
            fb_data    <= data_nxt;
            fb_we      <= we_nxt;
            frame_done <= done_nxt;
            dith_clr   <= clr_nxt;
            sync_err   <= err_nxt;
        end
    end

endmodule

// File: tb/tb_dither_pixel_writer.sv
// Directed bench for dither_pixel_writer with a 4x2 frame.
module tb_dither_pixel_writer;

    localparam int unsigned H = 4;
    localparam int unsigned V = 2;
    localparam int unsigned AW = 3;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [7:0]    in_color;
    logic          in_sof;
    logic          fb_we;
    logic          fb_ready;
    logic [AW-1:0] fb_addr;
    logic [11:0]   fb_data;
    logic          frame_done;
    logic          dith_clr;
    logic          sync_err;

    int cmp = 0;
    int err = 0;

    int fd_cnt = 0;
    int dc_cnt = 0;
    int se_cnt = 0;
    logic [AW-1:0] wa[$];
    logic [11:0]   wd[$];

    dither_pixel_writer #(.H_PIXELS(H), .V_PIXELS(V), .ADDR_W(AW)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_color(in_color), .in_sof(in_sof),
        .fb_we(fb_we), .fb_ready(fb_ready), .fb_addr(fb_addr), .fb_data(fb_data),
        .frame_done(frame_done), .dith_clr(dith_clr), .sync_err(sync_err)
    );

    always #5 clk = ~clk;

    // Log accepted writes and count output pulses.
    always @(posedge clk) begin
        if (rst && fb_we && fb_ready) begin
            wa.push_back(fb_addr);
            wd.push_back(fb_data);
        end
    end

    always @(negedge clk) begin
        if (rst) begin
            if (frame_done) fd_cnt <= fd_cnt + 1;
            if (dith_clr)   dc_cnt <= dc_cnt + 1;
            if (sync_err)   se_cnt <= se_cnt + 1;
        end
    end

    task automatic do_reset();
        in_valid = 1'b0;
        in_color = 8'h00;
        in_sof   = 1'b0;
        fb_ready = 1'b1;
        rst      = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1;
    endtask

    // Present one byte and hold it until it transfers; returns at posedge+1.
    task automatic send(input logic [7:0] c, input logic s);
        int n;
        n = 0;
        in_valid = 1'b1;
        in_color = c;
        in_sof   = s;
        while (!in_ready && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        cmp++;
        if (!in_ready) begin
            err++;
            $display("FAIL send_timeout: in_ready=%0b required=1", in_ready);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_sof   = 1'b0;
    endtask

    task automatic wait_writes(input int target, input string name);
        int n;
        n = 0;
        while (wa.size() < target && n < 60) begin
            @(posedge clk);
            #1;
            n++;
        end
        cmp++;
        if (wa.size() < target) begin
            err++;
            $display("FAIL %s_write_timeout: writes=%0d required=%0d", name, wa.size(), target);
        end
    endtask

    task automatic test_reset();
        in_valid = 1'b0;
        in_color = 8'h00;
        in_sof   = 1'b0;
        fb_ready = 1'b1;
        rst      = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        cmp++;
        if ({in_ready, fb_we, frame_done, dith_clr, sync_err} !== 5'b0) begin
            err++;
            $display("FAIL reset_ctrl: got=%b required=00000",
                     {in_ready, fb_we, frame_done, dith_clr, sync_err});
        end
        cmp++;
        if (fb_addr !== 3'd0 || fb_data !== 12'h000) begin
            err++;
            $display("FAIL reset_bus: addr=%0d data=%h required 0/000", fb_addr, fb_data);
        end
        #1 rst = 1'b1;
        @(posedge clk);
        #1;
        cmp++;
        if (in_ready !== 1'b1) begin
            err++;
            $display("FAIL reset_ready_after: in_ready=%b required=1", in_ready);
        end
    endtask

    task automatic test_drop_no_sof();
        int w0, d0;
        do_reset();
        w0 = wa.size();
        d0 = dc_cnt;
        send(8'h11, 1'b0);
        send(8'h22, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        cmp++;
        if (wa.size() != w0 || fb_we !== 1'b0 || dc_cnt != d0) begin
            err++;
            $display("FAIL drop_no_sof: writes=%0d fb_we=%b clr=%0d required 0/0/0",
                     wa.size() - w0, fb_we, dc_cnt - d0);
        end
        cmp++;
        if (in_ready !== 1'b1) begin
            err++;
            $display("FAIL drop_ready: in_ready=%b required=1", in_ready);
        end
    endtask

    task automatic test_first_pixel();
        // Follows the dropped bytes: still waiting for SOF.
        fb_ready = 1'b1;
        send(8'h30, 1'b1);
        cmp++;
        if (dith_clr !== 1'b1) begin
            err++;
            $display("FAIL first_dith_clr: dith_clr=%b required=1", dith_clr);
        end
        send(8'h50, 1'b0);
        cmp++;
        if (dith_clr !== 1'b0 || fb_we !== 1'b0) begin
            err++;
            $display("FAIL first_after_g: clr=%b we=%b required 0/0", dith_clr, fb_we);
        end
        send(8'hA0, 1'b0);
        cmp++;
        if (fb_we !== 1'b1 || fb_addr !== 3'd0 || fb_data !== 12'h35A || in_ready !== 1'b0) begin
            err++;
            $display("FAIL first_write: we=%b addr=%0d data=%h rdy=%b required 1/0/35a/0",
                     fb_we, fb_addr, fb_data, in_ready);
        end
        @(posedge clk);
        #1;
        cmp++;
        if (fb_we !== 1'b0 || fb_addr !== 3'd1 || in_ready !== 1'b1) begin
            err++;
            $display("FAIL first_accept: we=%b addr=%0d rdy=%b required 0/1/1", fb_we, fb_addr, in_ready);
        end
    endtask

    task automatic test_full_frame();
        int w0, f0, s0, n;
        logic [3:0] i4;
        logic [11:0] exp_d;
        do_reset();
        w0 = wa.size();
        f0 = fd_cnt;
        s0 = se_cnt;
        for (int i = 0; i < 8; i++) begin
            i4 = 4'(i);
            send({i4, 4'h3}, i == 0);
            send({i4 + 4'd8, 4'h0}, 1'b0);
            send({4'd15 - i4, 4'hC}, 1'b0);
        end
        wait_writes(w0 + 8, "frame");
        n = 0;
        while (fd_cnt == f0 && n < 10) begin
            @(posedge clk);
            #1;
            n++;
        end
        repeat (3) @(posedge clk);
        #1;
        for (int i = 0; i < 8; i++) begin
            i4 = 4'(i);
            exp_d = {i4, i4 + 4'd8, 4'd15 - i4};
            cmp++;
            if (w0 + i >= wa.size() || wa[w0 + i] !== 3'(i) || wd[w0 + i] !== exp_d) begin
                err++;
                $display("FAIL frame_write%0d: addr=%0d data=%h required %0d/%h", i,
                         (w0 + i < wa.size()) ? wa[w0 + i] : 3'd0,
                         (w0 + i < wd.size()) ? wd[w0 + i] : 12'h0, i, exp_d);
            end
        end
        cmp++;
        if (fd_cnt - f0 != 1 || wa.size() - w0 != 8) begin
            err++;
            $display("FAIL frame_done_count: pulses=%0d writes=%0d required 1/8", fd_cnt - f0, wa.size() - w0);
        end
        cmp++;
        if (fb_addr !== 3'd0 || in_ready !== 1'b1 || fb_we !== 1'b0 || se_cnt != s0) begin
            err++;
            $display("FAIL frame_end_state: addr=%0d rdy=%b we=%b serr=%0d required 0/1/0/0",
                     fb_addr, in_ready, fb_we, se_cnt - s0);
        end
    endtask

    task automatic test_stall();
        int w0;
        do_reset();
        w0 = wa.size();
        fb_ready = 1'b0;
        send(8'h12, 1'b1);
        send(8'h34, 1'b1);
        send(8'h56, 1'b0);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            cmp++;
            if (fb_we !== 1'b1 || fb_addr !== 3'd0 || fb_data !== 12'h135 || in_ready !== 1'b0) begin
                err++;
                $display("FAIL stall_hold%0d: we=%b addr=%0d data=%h rdy=%b required 1/0/135/0",
                         c, fb_we, fb_addr, fb_data, in_ready);
            end
        end
        @(posedge clk);
        #1 fb_ready = 1'b1;
        @(posedge clk);
        #1;
        cmp++;
        if (fb_we !== 1'b0 || fb_addr !== 3'd1 || wa.size() - w0 != 1) begin
            err++;
            $display("FAIL stall_release: we=%b addr=%0d writes=%0d required 0/1/1",
                     fb_we, fb_addr, wa.size() - w0);
        end
    endtask

    task automatic test_low_nibbles();
        int w0;
        w0 = wa.size();
        send(8'hFF, 1'b0);
        send(8'h0F, 1'b0);
        send(8'h8C, 1'b0);
        wait_writes(w0 + 1, "nibble");
        cmp++;
        if (wa.size() <= w0 || wd[w0] !== 12'hF08 || wa[w0] !== 3'd1) begin
            err++;
            $display("FAIL low_nibbles: data=%h addr=%0d required f08/1",
                     (wd.size() > w0) ? wd[w0] : 12'h0, (wa.size() > w0) ? wa[w0] : 3'd0);
        end
    endtask

    task automatic test_sof_in_get_r();
        int w0, d0, s0, f0;
        logic [AW-1:0] exp_a;
        int exp_se;
        do_reset();
        w0 = wa.size();
        for (int i = 0; i < 3; i++) begin
            send(8'h10, i == 0);
            send(8'h20, 1'b0);
            send(8'h30, 1'b0);
        end
        wait_writes(w0 + 3, "sof_pre");
        @(posedge clk);
        #1;
        d0 = dc_cnt;
        s0 = se_cnt;
        f0 = fd_cnt;
        send(8'h70, 1'b1);
        send(8'h80, 1'b0);
        send(8'h90, 1'b0);
        wait_writes(w0 + 4, "sof");
        repeat (2) @(posedge clk);
        #1;
`ifdef DITHER_PIXEL_WRITER_SOF_RESYNC_EN
        exp_a  = 3'd0;
        exp_se = 1;
`else
        exp_a  = 3'd3;
        exp_se = 0;
`endif
        cmp++;
        if (wa.size() <= w0 + 3 || wa[w0 + 3] !== exp_a || wd[w0 + 3] !== 12'h789) begin
            err++;
            $display("FAIL sof_get_r_write: addr=%0d data=%h required %0d/789",
                     (wa.size() > w0 + 3) ? wa[w0 + 3] : 3'd7,
                     (wd.size() > w0 + 3) ? wd[w0 + 3] : 12'h0, exp_a);
        end
        cmp++;
        if (se_cnt - s0 != exp_se || dc_cnt - d0 != exp_se || fd_cnt != f0) begin
            err++;
            $display("FAIL sof_get_r_pulses: serr=%0d clr=%0d done=%0d required %0d/%0d/0",
                     se_cnt - s0, dc_cnt - d0, fd_cnt - f0, exp_se, exp_se);
        end
    endtask

    initial begin
        test_reset();
        test_drop_no_sof();
        test_first_pixel();
        test_full_frame();
        test_stall();
        test_low_nibbles();
        test_sof_in_get_r();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, err);
        $finish;
    end

endmodule

// File: doc/dither_pixel_writer.md
Name: dither_pixel_writer

Overview:
- Downstream neighbour of the 8-bit dithering stage in the VGA serial display path.
- Consumes the dithered colour byte stream (R, G, B per pixel, upper nibble significant) and packs the three nibbles into one 12-bit RGB444 word.
- Writes each word into the VGA frame buffer at a linear raster address, with a valid/ready handshake upstream and a write/ready handshake to the frame buffer.
- Emits frame-done and dither-clear pulses for frame sequencing.

Parameters:
- H_PIXELS, 320, pixels per line.
- V_PIXELS, 240, lines per frame.
- ADDR_W, 17, frame-buffer address width; must satisfy 2**ADDR_W >= H_PIXELS*V_PIXELS.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  reset, asynchronous, active-low.
- in_valid  in  1  dithered byte valid.
- in_ready  out  1  writer can accept a byte.
- in_color  in  8  dithered channel byte; bits [7:4] used, bits [3:0] ignored.
- in_sof  in  1  qualifies the current byte as the R byte of pixel 0 of a frame.
- fb_we  out  1  frame-buffer write request.
- fb_ready  in  1  frame buffer accepts the write this cycle.
- fb_addr  out  ADDR_W  linear pixel address, y*H_PIXELS + x.
- fb_data  out  12  {R[3:0], G[3:0], B[3:0]}.
- frame_done  out  1  1-cycle pulse after the last pixel of a frame is written.
- dith_clr  out  1  1-cycle pulse when a frame starts; clears the upstream dither error.
- sync_err  out  1  1-cycle pulse on a framing error.

Behaviour:
- Reset (rst=0, async): state WAIT_SOF. in_ready=0, fb_we=0, fb_addr=0, fb_data=0, frame_done=0, dith_clr=0, sync_err=0. Internal x=0, y=0, nibble registers 0.
- A byte transfers when in_valid && in_ready on a rising edge.
- States:
  - WAIT_SOF: in_ready=1. Bytes with in_sof=0 are dropped silently. A byte with in_sof=1 stores R, pulses dith_clr next cycle, and moves to GET_G.
  - GET_G: in_ready=1. A transfer stores G and moves to GET_B.
  - GET_B: in_ready=1. A transfer stores B and moves to WRITE.
  - WRITE: in_ready=0. fb_we=1, fb_data and fb_addr are stable until fb_we && fb_ready.
    - On acceptance: fb_we drops next cycle.
    - If this was not the last pixel: address advances and state goes to GET_R.
    - If it was the last pixel: x=0, y=0, fb_addr=0, frame_done pulses 1 cycle, state goes to WAIT_SOF.
  - GET_R: in_ready=1. A transfer stores R and moves to GET_G. in_sof handling in this state is governed by the optional feature.
- Latency: fb_we is asserted the cycle after the B byte transfers. Minimum 4 cycles per pixel when fb_ready is held at 1.
- Addressing:
  - x counts 0..H_PIXELS-1, then wraps to 0 and y increments.
  - Last pixel is x=H_PIXELS-1 and y=V_PIXELS-1.
  - fb_addr is a registered linear counter incremented by 1 per write; no multiplier.
- in_sof=1 on a G or B byte is ignored; the byte is taken as colour.
- fb_ready is ignored outside WRITE.
- Reset mid-frame discards partial pixel and counters; no frame_done is generated.
- Outputs are registered; in_ready is combinational from state only.

Optional Feature:
- Macro: DITHER_PIXEL_WRITER_SOF_RESYNC_EN.
- Defined: in GET_R, a transferred byte with in_sof=1 (unless at address 0) resynchronises the writer:
  - sync_err pulses 1 cycle and dith_clr pulses 1 cycle.
  - x=0, y=0, fb_addr=0.
  - The byte is stored as R of pixel 0 and state goes to GET_G.
  - No frame_done is generated for the aborted frame.
- Not defined: in_sof is ignored in GET_R and the byte is stored as R. sync_err is tied to 0.

Test Plan (H_PIXELS=4, V_PIXELS=2, ADDR_W=3):
- Reset, then bytes 0x30(sof),0x50,0xA0 with fb_ready=1 -> dith_clr pulse; fb_we=1 with fb_addr=0 and fb_data=0x35A one cycle after B; fb_addr=1 afterwards.
- Bytes 0x11,0x22 without sof after reset -> both dropped, no fb_we, state stays WAIT_SOF.
- 24 bytes, full frame, continuous valid, fb_ready=1 -> 8 writes at addresses 0..7; frame_done pulses once after write 7; fb_addr returns 0; in_ready=1 in WAIT_SOF.
- fb_ready=0 for 5 cycles during WRITE -> fb_we, fb_addr, fb_data held constant; in_ready=0 throughout; completes when fb_ready=1.
- Low nibbles 0xFF,0x0F,0x8C -> fb_data=0xF08.
- With DITHER_PIXEL_WRITER_SOF_RESYNC_EN: in_sof on R byte of pixel 3 -> sync_err and dith_clr pulse; next write at fb_addr=0.
- Without DITHER_PIXEL_WRITER_SOF_RESYNC_EN: in_sof on R byte of pixel 3 -> pixel written at fb_addr=3; sync_err stays 0.
